// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-bus CPU control sequencer: opcodes,
// sequencer states, opcode classes and IR field positions.
package cpu_defs_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;
   localparam int C_MSB   = 18;
   localparam int C_LSB   = 0;

   typedef enum logic [3:0] {
      ST_RESET,
      ST_F0,
      ST_F1,
      ST_F2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_PAUSED,
      ST_HALTED
   } state_e;

   typedef enum logic [2:0] {
      CL_ALU3,
      CL_IMM,
      CL_UNARY,
      CL_MULDIV,
      CL_NOP,
      CL_HALT,
      CL_ILLEGAL
   } op_class_e;

   function automatic logic [4:0] opcode_of(input logic [31:0] ir);
      return ir[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe/status bundle between the control sequencer (master) and the
// single-bus datapath (slave).
interface control_sequencer_if #(
   parameter int INSTR_CNT_W = 16
);
   logic [31:0]            IR;
   logic                   Mem_ready;
   logic                   Stop;

   logic                   PCout, MDRout, ZHighout, Zlowout, HIout, LOout, Cout;
   logic                   Gra, Grb, Grc, Rin, Rout;
   logic                   PCin, MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin;
   logic                   IncPC, Read;
   logic [4:0]             alu_op;
   logic                   Run;
   logic                   Illegal;
   logic [INSTR_CNT_W-1:0] instr_count;

   modport master (
      input  IR, Mem_ready, Stop,
      output PCout, MDRout, ZHighout, Zlowout, HIout, LOout, Cout,
      output Gra, Grb, Grc, Rin, Rout,
      output PCin, MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin,
      output IncPC, Read, alu_op, Run, Illegal, instr_count
   );

   modport slave (
      output IR, Mem_ready, Stop,
      input  PCout, MDRout, ZHighout, Zlowout, HIout, LOout, Cout,
      input  Gra, Grb, Grc, Rin, Rout,
      input  PCin, MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin,
      input  IncPC, Read, alu_op, Run, Illegal, instr_count
   );

endinterface

// File: rtl/op_class_decode.sv
// Combinational opcode classifier; anything not listed is illegal.
module op_class_decode
   import cpu_defs_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_e  op_class
);

   always_comb begin
      op_class = CL_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:   op_class = CL_ALU3;
         OP_ADDI, OP_ANDI, OP_ORI:        op_class = CL_IMM;
         OP_MUL, OP_DIV:                  op_class = CL_MULDIV;
         OP_NEG, OP_NOT:                  op_class = CL_UNARY;
         OP_NOP:                          op_class = CL_NOP;
         OP_HALT:                         op_class = CL_HALT;
         default:                         op_class = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore micro-sequencer: fetch, decode and per-class execute
// strobes for the single-bus datapath, with pause, halt and retire count.
module control_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int INSTR_CNT_W = 16
) (
   input logic                 Clock,
   input logic                 Clear,
   control_sequencer_if.master bus
);

   state_e                 state_q, state_d;
   logic                   waited_q, waited_d;
   logic [INSTR_CNT_W-1:0] count_q;
   logic                   illegal_q;
   logic [4:0]             opcode;
   op_class_e              op_class;
   logic                   last_step;
   logic                   unused_ir;

   assign opcode    = opcode_of(bus.IR);
   assign unused_ir = ^bus.IR[RA_MSB:C_LSB];

   op_class_decode u_decode (
      .opcode   (opcode),
      .op_class (op_class)
   );

   // Final state of the instruction: the edge leaving it retires it.
   always_comb begin
      last_step = 1'b0;
      case (state_q)
         ST_F2:   last_step = (op_class == CL_NOP) || (op_class == CL_ILLEGAL);
         ST_T4:   last_step = (op_class == CL_UNARY);
         ST_T5:   last_step = (op_class == CL_ALU3) || (op_class == CL_IMM);
         ST_T6:   last_step = 1'b1;
         default: last_step = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q   <= ST_RESET;
         waited_q  <= 1'b0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         waited_q <= waited_d;
         if (last_step)
            count_q <= count_q + 1'b1;
         if (state_q == ST_F2 && op_class == CL_ILLEGAL)
            illegal_q <= 1'b1;
      end
   end

   assign bus.instr_count = count_q;
   assign bus.Illegal     = illegal_q;

   always_comb begin
      state_d      = state_q;
      waited_d     = 1'b0;
      bus.PCout    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.ZHighout = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.HIout    = 1'b0;
      bus.LOout    = 1'b0;
      bus.Cout     = 1'b0;
      bus.Gra      = 1'b0;
      bus.Grb      = 1'b0;
      bus.Grc      = 1'b0;
      bus.Rin      = 1'b0;
      bus.Rout     = 1'b0;
      bus.PCin     = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.ZHighIn  = 1'b0;
      bus.ZLowIn   = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.Read     = 1'b0;
      bus.alu_op   = 5'd0;
      bus.Run      = 1'b0;

      case (state_q)
         ST_RESET: state_d = ST_F0;
         ST_F0: begin
            bus.Run    = 1'b1;
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.ZLowIn = 1'b1;
            state_d    = ST_F1;
         end
         ST_F1: begin
            bus.Run     = 1'b1;
            bus.Zlowout = 1'b1;
            bus.PCin    = !waited_q;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            waited_d    = !bus.Mem_ready;
            state_d     = bus.Mem_ready ? ST_F2 : ST_F1;
         end
         ST_F2: begin
            bus.Run    = 1'b1;
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = (op_class == CL_HALT) ? ST_HALTED : ST_T3;
         end
         ST_T3: begin
            bus.Run = 1'b1;
            bus.Rout = 1'b1;
            state_d  = ST_T4;
            case (op_class)
               CL_UNARY: begin
                  bus.Grb    = 1'b1;
                  bus.ZLowIn = 1'b1;
                  bus.alu_op = opcode;
               end
               CL_MULDIV: begin
                  bus.Gra = 1'b1;
                  bus.Yin = 1'b1;
               end
               default: begin
                  bus.Grb = 1'b1;
                  bus.Yin = 1'b1;
               end
            endcase
         end
         ST_T4: begin
            bus.Run = 1'b1;
            state_d = ST_T5;
            case (op_class)
               CL_UNARY: begin
                  bus.Zlowout = 1'b1;
                  bus.Gra     = 1'b1;
                  bus.Rin     = 1'b1;
               end
               CL_IMM: begin
                  bus.Cout   = 1'b1;
                  bus.ZLowIn = 1'b1;
                  bus.alu_op = opcode;
               end
               CL_MULDIV: begin
                  bus.Grb     = 1'b1;
                  bus.Rout    = 1'b1;
                  bus.ZHighIn = 1'b1;
                  bus.ZLowIn  = 1'b1;
                  bus.alu_op  = opcode;
               end
               default: begin
                  bus.Grc    = 1'b1;
                  bus.Rout   = 1'b1;
                  bus.ZLowIn = 1'b1;
                  bus.alu_op = opcode;
               end
            endcase
         end
         ST_T5: begin
            bus.Run     = 1'b1;
            bus.Zlowout = 1'b1;
            state_d     = ST_T6;
            if (op_class == CL_MULDIV) begin
               bus.LOin = 1'b1;
            end else begin
               bus.Gra = 1'b1;
               bus.Rin = 1'b1;
            end
         end
         ST_T6: begin
            bus.Run      = 1'b1;
            bus.ZHighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         ST_PAUSED: state_d = bus.Stop ? ST_PAUSED : ST_F0;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RESET;
      endcase

      // Stop is only honoured at an instruction boundary.
      if (last_step)
         state_d = bus.Stop ? ST_PAUSED : ST_F0;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: per-cycle expected strobes/count/flag queued, then compared.
module tb_control_sequencer;
   import cpu_defs_pkg::*;

   localparam int CW = 3;

   localparam logic [28:0] RUN      = 29'h1 << 28;
   localparam logic [28:0] PCOUT    = 29'h1 << 22;
   localparam logic [28:0] MDROUT   = 29'h1 << 21;
   localparam logic [28:0] ZHIGHOUT = 29'h1 << 20;
   localparam logic [28:0] ZLOWOUT  = 29'h1 << 19;
   localparam logic [28:0] COUT     = 29'h1 << 16;
   localparam logic [28:0] GRA      = 29'h1 << 15;
   localparam logic [28:0] GRB      = 29'h1 << 14;
   localparam logic [28:0] GRC      = 29'h1 << 13;
   localparam logic [28:0] RIN      = 29'h1 << 12;
   localparam logic [28:0] ROUT     = 29'h1 << 11;
   localparam logic [28:0] PCIN     = 29'h1 << 10;
   localparam logic [28:0] MARIN    = 29'h1 << 9;
   localparam logic [28:0] MDRIN    = 29'h1 << 8;
   localparam logic [28:0] IRIN     = 29'h1 << 7;
   localparam logic [28:0] YIN      = 29'h1 << 6;
   localparam logic [28:0] ZHIGHIN  = 29'h1 << 5;
   localparam logic [28:0] ZLOWIN   = 29'h1 << 4;
   localparam logic [28:0] HIIN     = 29'h1 << 3;
   localparam logic [28:0] LOIN     = 29'h1 << 2;
   localparam logic [28:0] INCPC    = 29'h1 << 1;
   localparam logic [28:0] READ     = 29'h1;

   typedef struct packed {
      logic [28:0]   vec;
      logic [31:0]   ir;
      logic          rdy;
      logic          stop;
      logic          clr;
      logic [CW-1:0] cnt;
      logic          ill;
   } entry_t;

   logic clk;
   logic clear;
   logic [28:0] act;

   control_sequencer_if #(.INSTR_CNT_W(CW)) bus ();

   control_sequencer #(.INSTR_CNT_W(CW)) dut (
      .Clock (clk),
      .Clear (clear),
      .bus   (bus.master)
   );

   assign act = {bus.Run, bus.alu_op, bus.PCout, bus.MDRout, bus.ZHighout, bus.Zlowout,
                 bus.HIout, bus.LOout, bus.Cout, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                 bus.Rout, bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin,
                 bus.ZHighIn, bus.ZLowIn, bus.HIin, bus.LOin, bus.IncPC, bus.Read};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   entry_t        q[$];
   string         tq[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] m_cnt = '0;
   logic          m_ill = 1'b0;
   logic [31:0]   last_ir = 32'h0;

   // 0 ALU3, 1 IMM, 2 UNARY, 3 MULDIV, 4 NOP, 5 HALT, 6 ILLEGAL
   function automatic int cls(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd10) return 0;
      if (op >= 5'd11 && op <= 5'd13) return 1;
      if (op == 5'd16 || op == 5'd17) return 2;
      if (op == 5'd14 || op == 5'd15) return 3;
      if (op == 5'd26) return 4;
      if (op == 5'd27) return 5;
      return 6;
   endfunction

   function automatic logic [28:0] exec_vec(input logic [4:0] op, input int k);
      logic [28:0] a;
      a = RUN | (29'(op) << 23);
      case (cls(op))
         0: case (k)
               3: return RUN | GRB | ROUT | YIN;
               4: return a | GRC | ROUT | ZLOWIN;
               default: return RUN | ZLOWOUT | GRA | RIN;
            endcase
         1: case (k)
               3: return RUN | GRB | ROUT | YIN;
               4: return a | COUT | ZLOWIN;
               default: return RUN | ZLOWOUT | GRA | RIN;
            endcase
         2: case (k)
               3: return a | GRB | ROUT | ZLOWIN;
               default: return RUN | ZLOWOUT | GRA | RIN;
            endcase
         default: case (k)
               3: return RUN | GRA | ROUT | YIN;
               4: return a | GRB | ROUT | ZHIGHIN | ZLOWIN;
               5: return RUN | ZLOWOUT | LOIN;
               default: return RUN | ZHIGHOUT | HIIN;
            endcase
      endcase
   endfunction

   task automatic push(input string t, input logic [28:0] v, input logic [31:0] ir,
                       input logic rdy, input logic stp, input logic clr);
      entry_t e;
      e.vec = v; e.ir = ir; e.rdy = rdy; e.stop = stp; e.clr = clr;
      e.cnt = m_cnt; e.ill = m_ill;
      q.push_back(e);
      tq.push_back(t);
      last_ir = ir;
   endtask

   task automatic push_instr(input string t, input logic [31:0] ir, input int waits,
                             input int stop_from);
      logic [4:0] op;
      int c, n;
      op = ir[31:27];
      c  = cls(op);
      push({t, ".F0"}, RUN | PCOUT | MARIN | INCPC | ZLOWIN, ir, 1'b1, 1'b0, 1'b1);
      push({t, ".F1"}, RUN | ZLOWOUT | PCIN | READ | MDRIN, ir, waits == 0, 1'b0, 1'b1);
      for (int i = 0; i < waits; i++)
         push({t, ".F1w"}, RUN | ZLOWOUT | READ | MDRIN, ir, i == waits - 1, 1'b0, 1'b1);
      push({t, ".F2"}, RUN | MDROUT | IRIN, ir, 1'b1, stop_from <= 2, 1'b1);
      n = (c == 0 || c == 1) ? 3 : (c == 2) ? 2 : (c == 3) ? 4 : 0;
      for (int k = 3; k < 3 + n; k++)
         push($sformatf("%s.T%0d", t, k), exec_vec(op, k), ir, 1'b1, k >= stop_from, 1'b1);
      if (c != 5) m_cnt = m_cnt + 1'b1;
      if (c == 6) m_ill = 1'b1;
   endtask

   task automatic push_idle(input string t, input int n, input logic stp);
      for (int i = 0; i < n; i++) push(t, 29'h0, last_ir, 1'b1, stp, 1'b1);
   endtask

   task automatic push_clear();
      m_cnt = '0;
      m_ill = 1'b0;
      push("CLR", 29'h0, last_ir, 1'b1, 1'b0, 1'b0);
      push("RST", 29'h0, last_ir, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic step_one();
      entry_t e;
      string  t;
      @(negedge clk);
      e = q.pop_front();
      t = tq.pop_front();
      bus.IR        = e.ir;
      bus.Mem_ready = e.rdy;
      bus.Stop      = e.stop;
      clear         = e.clr;
      #1;
      n_cmp++;
      assert (act === e.vec) else begin
         n_bad++;
         $error("FAIL %s strobes: got %h want %h", t, act, e.vec);
      end
      n_cmp++;
      assert (bus.instr_count === e.cnt) else begin
         n_bad++;
         $error("FAIL %s instr_count: got %0d want %0d", t, bus.instr_count, e.cnt);
      end
      n_cmp++;
      assert (bus.Illegal === e.ill) else begin
         n_bad++;
         $error("FAIL %s Illegal: got %b want %b", t, bus.Illegal, e.ill);
      end
   endtask

   task automatic run_queue();
      while (q.size() > 0) step_one();
   endtask

   task automatic check_cleared(input string t);
      n_cmp++;
      assert (act === 29'h0) else begin
         n_bad++;
         $error("FAIL %s strobes: got %h want 0", t, act);
      end
      n_cmp++;
      assert (bus.instr_count === '0) else begin
         n_bad++;
         $error("FAIL %s instr_count: got %0d want 0", t, bus.instr_count);
      end
      n_cmp++;
      assert (bus.Illegal === 1'b0) else begin
         n_bad++;
         $error("FAIL %s Illegal: got %b want 0", t, bus.Illegal);
      end
   endtask

   initial begin
      clear         = 1'b0;
      bus.IR        = 32'h0;
      bus.Mem_ready = 1'b1;
      bus.Stop      = 1'b0;
      #2;
      check_cleared("reset");

      push("RST", 29'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      push_instr("ADD", 32'h1A920000, 0, 99);
      push_instr("NOT", 32'h8A900000, 0, 99);
      push_instr("MUL", 32'h71880000, 3, 99);
      push_instr("ADDs", 32'h1A920000, 0, 4);
      push_idle("PAUSED", 1, 1'b1);
      push_idle("PAUSED", 1, 1'b0);
      push_instr("ADDI", 32'h58000000, 1, 99);
      push_instr("DIV", 32'h78000000, 0, 99);
      push_instr("ILL", 32'hF8000000, 0, 99);
      push_instr("NOP", 32'hD0000000, 0, 99);
      push_instr("SHL", 32'h30000000, 0, 2);
      push_idle("PAUSED", 2, 1'b1);
      push_idle("PAUSED", 1, 1'b0);
      push_instr("HALT", 32'hD8000000, 0, 2);
      push_idle("HALTED", 2, 1'b1);
      push_idle("HALTED", 2, 1'b0);
      push_clear();
      push_instr("ILL2", 32'hF8000000, 0, 99);
      push_instr("ADD2", 32'h1A920000, 0, 99);
      run_queue();

      // Abort an ADD in T4 with an asynchronous clear between edges.
      push_instr("ADDc", 32'h1A920000, 0, 99);
      for (int i = 0; i < 5; i++) step_one();
      q.delete();
      tq.delete();
      #2 clear = 1'b0;
      #1 check_cleared("midT4_clear");

      push_clear();
      push_instr("NOP2", 32'hD0000000, 0, 99);
      push_idle("F0", 0, 1'b0);
      push("F0", RUN | PCOUT | MARIN | INCPC | ZLOWIN, 32'hD0000000, 1'b1, 1'b0, 1'b1);
      run_queue();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timed out");
   end

endmodule
